// File: rtl/rtc_bus_pkg.sv
// RTC bus constants: register addresses, the slot<->address table and the read FSM encoding.
package rtc_bus_pkg;

    localparam int N_SLOTS_MAX = 9;

    localparam logic [7:0] ADDR_SEG        = 8'h21;
    localparam logic [7:0] ADDR_MIN        = 8'h22;
    localparam logic [7:0] ADDR_HORA       = 8'h23;
    localparam logic [7:0] ADDR_DIA        = 8'h24;
    localparam logic [7:0] ADDR_MES        = 8'h25;
    localparam logic [7:0] ADDR_ANO        = 8'h26;
    localparam logic [7:0] ADDR_SEG_TIMER  = 8'h41;
    localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
    localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_HOLD,
        ST_READ,
        ST_RECOV,
        ST_DONE
    } state_t;

    // Slot 0 and anything past the timer block have no register behind them.
    function automatic logic [7:0] slot_to_addr(input logic [3:0] slot);
        logic [7:0] addr;
        case (slot)
            4'd1:    addr = ADDR_SEG;
            4'd2:    addr = ADDR_MIN;
            4'd3:    addr = ADDR_HORA;
            4'd4:    addr = ADDR_DIA;
            4'd5:    addr = ADDR_MES;
            4'd6:    addr = ADDR_ANO;
            4'd7:    addr = ADDR_SEG_TIMER;
            4'd8:    addr = ADDR_MIN_TIMER;
            4'd9:    addr = ADDR_HORA_TIMER;
            default: addr = 8'h00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Control, AD bus and read-result signals of the RTC read sequencer.
// master = sequencer side, slave = RTC device / consumer side.
interface rtc_read_sequencer_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       cs_n;
    logic       ad_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] data_out;
    logic [3:0] slot;
    logic       data_valid;
    logic       addr_err;

    modport master (
        input  start, ad_in,
        output busy, done, ad_out, ad_oe, cs_n, ad_n, rd_n, wr_n,
               data_out, slot, data_valid, addr_err
    );

    modport slave (
        output start, ad_in,
        input  busy, done, ad_out, ad_oe, cs_n, ad_n, rd_n, wr_n,
               data_out, slot, data_valid, addr_err
    );
endinterface

// File: rtl/rtc_addr_encoder.sv
// Address -> slot encoder, the inverse of slot_to_addr; combinational, zero latency, no backpressure.
// Unmapped addresses give slot 0 with o_valid low.
module rtc_addr_encoder
    import rtc_bus_pkg::*;
(
    input  logic [7:0] i_addr,
    output logic [3:0] o_slot,
    output logic       o_valid
);

    always_comb begin
        o_slot  = 4'd0;
        o_valid = 1'b0;
        for (int s = 1; s <= N_SLOTS_MAX; s++) begin
            if (i_addr == slot_to_addr(4'(s))) begin
                o_slot  = 4'(s);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps RTC slots 1..N_SLOTS with ADDR/HOLD/READ/RECOV bus cycles of T_PHASE clocks each;
// first data_valid 3*T_PHASE+1 after start, done at 4*T_PHASE*N_SLOTS+1; start ignored while busy.
module rtc_read_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = 4,
    parameter int N_SLOTS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_read_sequencer_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_phase;
    logic [3:0] r_cur;
    logic [3:0] w_next_cur;
    logic       w_phase_last;
    logic       w_capture;
    logic [3:0] w_enc_slot;
    logic       w_enc_valid;

    logic       r_busy, r_done, r_ad_oe, r_cs_n, r_ad_n, r_rd_n;
    logic       r_data_valid, r_addr_err;
    logic [7:0] r_ad_out, r_data_out;
    logic [3:0] r_slot;

    assign w_phase_last = (r_phase == 4'(T_PHASE - 1));

    rtc_addr_encoder u_encoder (
        .i_addr  (slot_to_addr(r_cur)),
        .o_slot  (w_enc_slot),
        .o_valid (w_enc_valid)
    );

    always_comb begin
        w_next     = r_state;
        w_next_cur = r_cur;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next     = ST_ADDR;
                    w_next_cur = 4'd1;
                end
            end
            ST_ADDR:  if (w_phase_last) w_next = ST_HOLD;
            ST_HOLD:  if (w_phase_last) w_next = ST_READ;
            ST_READ: begin
                if (w_phase_last) begin
                    w_next    = ST_RECOV;
                    w_capture = 1'b1;
                end
            end
            ST_RECOV: begin
                if (w_phase_last) begin
                    if (r_cur == 4'(N_SLOTS)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_ADDR;
                        w_next_cur = r_cur + 4'd1;
                    end
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= 4'd0;
            r_cur   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cur   <= w_next_cur;
            if (w_next != r_state) begin
                r_phase <= 4'd0;
            end else if (r_state != ST_IDLE) begin
                r_phase <= r_phase + 4'd1;
            end
        end
    end

    // Outputs are decoded from the next state so the pins line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ad_oe      <= 1'b0;
            r_cs_n       <= 1'b1;
            r_ad_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_ad_out     <= 8'h00;
            r_data_out   <= 8'h00;
            r_slot       <= 4'd0;
            r_data_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_busy       <= (w_next != ST_IDLE);
            r_done       <= (w_next == ST_DONE);
            r_ad_oe      <= (w_next == ST_ADDR);
            r_cs_n       <= !(w_next inside {ST_ADDR, ST_HOLD, ST_READ});
            r_ad_n       <= (w_next != ST_ADDR);
            r_rd_n       <= (w_next != ST_READ);
            r_data_valid <= w_capture;
            if (w_next == ST_ADDR) begin
                r_ad_out <= slot_to_addr(w_next_cur);
            end
            if (w_capture) begin
                r_data_out <= bus.ad_in;
                r_slot     <= w_enc_slot;
            end
            if (r_state == ST_IDLE && bus.start) begin
                r_addr_err <= 1'b0;
            end else if (w_capture && !w_enc_valid) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.ad_out     = r_ad_out;
    assign bus.ad_oe      = r_ad_oe;
    assign bus.cs_n       = r_cs_n;
    assign bus.ad_n       = r_ad_n;
    assign bus.rd_n       = r_rd_n;
    assign bus.wr_n       = 1'b1;
    assign bus.data_out   = r_data_out;
    assign bus.slot       = r_slot;
    assign bus.data_valid = r_data_valid;
    assign bus.addr_err   = r_addr_err;

endmodule
